// File: rtl/w5300_tx_packer.sv
// w5300_tx_packer
//
// Packs a byte stream big-endian into 16-bit words in a local frame buffer.
// When the last byte arrives, the block raises an active-low transmit request
// and serves asynchronous word reads to the W5300 transmitter. The request
// stays low until the transmitter pulses tx_done. Only one frame is held at a
// time. A frame longer than MAX_BYTES is dropped and flagged on frame_ovf.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_data/s_valid/
//   s_last/s_ready      byte stream input (accept on s_valid & s_ready)
//   eth_tx_req          active-low transmit request (low for the whole send)
//   eth_tx_bytes        frame length in bytes, stable while eth_tx_req is low
//   eth_tx_buffer_addr  word read address from the transmitter
//   eth_tx_buffer_data  word at eth_tx_buffer_addr (combinational read)
//   tx_done             one-cycle completion pulse from the transmitter
//   frame_ovf           one-cycle pulse when an oversize frame is dropped
module w5300_tx_packer #(
    parameter int ETH_TX_BUFFER_WIDTH = 12,
    parameter int MAX_BYTES           = 8192
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     s_data,
    input  logic                           s_valid,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic                           eth_tx_req,
    output logic [16:0]                    eth_tx_bytes,
    input  logic [ETH_TX_BUFFER_WIDTH-1:0] eth_tx_buffer_addr,
    output logic [15:0]                    eth_tx_buffer_data,
    input  logic                           tx_done,
    output logic                           frame_ovf
);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_SEND    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [16:0] MAX_CNT = 17'(MAX_BYTES);
    localparam logic [ETH_TX_BUFFER_WIDTH-1:0] PTR_ONE = ETH_TX_BUFFER_WIDTH'(1);
    localparam int DEPTH = 1 << ETH_TX_BUFFER_WIDTH;

    logic [15:0] mem [0:DEPTH-1];

    state_t                         state_q, state_d;
    logic [16:0]                    byte_cnt_q, byte_cnt_d;
    logic [7:0]                     hi_byte_q, hi_byte_d;
    logic [ETH_TX_BUFFER_WIDTH-1:0] word_ptr_q, word_ptr_d;
    logic                           eth_tx_req_q, eth_tx_req_d;
    logic [16:0]                    eth_tx_bytes_q, eth_tx_bytes_d;
    logic                           frame_ovf_q, frame_ovf_d;

    logic                           mem_we_s;
    logic [ETH_TX_BUFFER_WIDTH-1:0] mem_waddr_s;
    logic [15:0]                    mem_wdata_s;
    logic                           s_ready_s;
    logic                           accept_s;

    assign s_ready_s          = (state_q != ST_SEND);
    assign accept_s           = s_valid & s_ready_s;
    assign s_ready            = s_ready_s;
    assign eth_tx_req         = eth_tx_req_q;
    assign eth_tx_bytes       = eth_tx_bytes_q;
    assign frame_ovf          = frame_ovf_q;
    // The transmitter samples the word in the same cycle it drives the address.
    assign eth_tx_buffer_data = mem[eth_tx_buffer_addr];

    // Next-state, packing and buffer write control.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        hi_byte_d      = hi_byte_q;
        word_ptr_d     = word_ptr_q;
        eth_tx_req_d   = eth_tx_req_q;
        eth_tx_bytes_d = eth_tx_bytes_q;
        frame_ovf_d    = 1'b0;
        mem_we_s       = 1'b0;
        mem_waddr_s    = word_ptr_q;
        mem_wdata_s    = 16'h0000;

        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    if (byte_cnt_q == MAX_CNT) begin
                        // Oversize: drop the frame; a trailing last byte ends it here.
                        frame_ovf_d = 1'b1;
                        byte_cnt_d  = 17'd0;
                        word_ptr_d  = '0;
                        if (s_last) begin
                            state_d = ST_FILL;
                        end else begin
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 17'd1;
                        if (byte_cnt_q[0]) begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = {hi_byte_q, s_data};
                            word_ptr_d  = word_ptr_q + PTR_ONE;
                        end else begin
                            hi_byte_d = s_data;
                            if (s_last) begin
                                // Odd-length frame: pad the final low byte with zero.
                                mem_we_s    = 1'b1;
                                mem_wdata_s = {s_data, 8'h00};
                            end else begin
                                mem_we_s = 1'b0;
                            end
                        end
                        if (s_last) begin
                            eth_tx_bytes_d = byte_cnt_q + 17'd1;
                            eth_tx_req_d   = 1'b0;
                            state_d        = ST_SEND;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    eth_tx_req_d = 1'b1;
                    byte_cnt_d   = 17'd0;
                    word_ptr_d   = '0;
                    state_d      = ST_FILL;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DISCARD: begin
                if (accept_s && s_last) begin
                    byte_cnt_d = 17'd0;
                    word_ptr_d = '0;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d      = ST_FILL;
                byte_cnt_d   = 17'd0;
                word_ptr_d   = '0;
                eth_tx_req_d = 1'b1;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FILL;
            byte_cnt_q     <= 17'd0;
            hi_byte_q      <= 8'h00;
            word_ptr_q     <= '0;
            eth_tx_req_q   <= 1'b1;
            eth_tx_bytes_q <= 17'd0;
            frame_ovf_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            hi_byte_q      <= hi_byte_d;
            word_ptr_q     <= word_ptr_d;
            eth_tx_req_q   <= eth_tx_req_d;
            eth_tx_bytes_q <= eth_tx_bytes_d;
            frame_ovf_q    <= frame_ovf_d;
        end
    end

    // Frame buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

endmodule
